// File: rtl/spm_responder.sv
// spm_responder: single-port memory plus 8-bit control/status registers.
// Optional feature macro SPM_WR_PROTECT_EN implements CTRL.WP protection.
module spm_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic [ADDR_WIDTH-1:0] i_reg_addr,
    input  logic                  i_reg_access_valid,
    input  logic                  i_reg_wr_rd,
    input  logic [7:0]            i_reg_wr_data,
    output logic                  o_reg_rd_data_valid,
    output logic [7:0]            o_reg_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_WCNT = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_RCNT = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_SCR  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(5);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic       r_en;
    logic       r_coll;
    logic       r_ovr;
    logic [7:0] r_wr_cnt;
    logic [7:0] r_rd_cnt;
    logic [7:0] r_scratch;
    logic [7:0] r_last_addr;
    logic [7:0] r_cap;

    logic       w_wp;
    logic       w_wpv;

    logic       w_reg_wr;
    logic       w_reg_cap;
    logic       w_reg_resp;
    logic       w_ovr_set;
    logic [7:0] w_reg_mux;

    logic w_sel_ctrl;
    logic w_sel_stat;
    logic w_sel_wcnt;
    logic w_sel_rcnt;
    logic w_sel_scr;
    logic w_sel_last;

    logic w_mem_req_wr;
    logic w_mem_wr;
    logic w_mem_rd;
    logic w_coll_set;
    logic w_wpv_set;
    logic w_clr_coll;
    logic w_clr_ovr;
    logic w_clr_wpv;

    assign w_sel_ctrl = (i_reg_addr == A_CTRL);
    assign w_sel_stat = (i_reg_addr == A_STAT);
    assign w_sel_wcnt = (i_reg_addr == A_WCNT);
    assign w_sel_rcnt = (i_reg_addr == A_RCNT);
    assign w_sel_scr  = (i_reg_addr == A_SCR);
    assign w_sel_last = (i_reg_addr == A_LAST);

    // A simultaneous write wins over the read; the read is dropped.
    assign w_mem_req_wr = i_wr_en & r_en;
    assign w_mem_wr     = w_mem_req_wr & ~w_wp;
    assign w_mem_rd     = i_rd_en & r_en & ~i_wr_en;
    assign w_coll_set   = i_rd_en & i_wr_en & r_en;
    assign w_wpv_set    = w_mem_req_wr & w_wp;

    assign w_clr_coll = w_reg_wr & w_sel_stat & i_reg_wr_data[0];
    assign w_clr_ovr  = w_reg_wr & w_sel_stat & i_reg_wr_data[1];
    assign w_clr_wpv  = w_reg_wr & w_sel_stat & i_reg_wr_data[2];

`ifdef SPM_WR_PROTECT_EN
    logic r_wp;
    logic r_wpv;

    assign w_wp  = r_wp;
    assign w_wpv = r_wpv;

    // Write-protect bit and its sticky violation flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= 1'b0;
            r_wpv <= 1'b0;
        end else begin
            if (w_reg_wr && w_sel_ctrl) begin
                r_wp <= i_reg_wr_data[1];
            end
            r_wpv <= w_wpv_set | (r_wpv & ~w_clr_wpv);
        end
    end
`else
    assign w_wp  = 1'b0;
    assign w_wpv = 1'b0;
`endif

    // Register FSM state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and access qualifiers.
    always_comb begin
        w_state_nxt = r_state;
        w_reg_wr    = 1'b0;
        w_reg_cap   = 1'b0;
        w_reg_resp  = 1'b0;
        w_ovr_set   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_reg_access_valid) begin
                    if (i_reg_wr_rd) begin
                        w_reg_cap   = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_reg_wr = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_reg_resp  = 1'b1;
                w_ovr_set   = i_reg_access_valid;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Register read mux; unmapped addresses read zero.
    always_comb begin
        w_reg_mux = 8'h00;
        unique case (1'b1)
            w_sel_ctrl: w_reg_mux = {6'b0, w_wp, r_en};
            w_sel_stat: w_reg_mux = {5'b0, w_wpv, r_ovr, r_coll};
            w_sel_wcnt: w_reg_mux = r_wr_cnt;
            w_sel_rcnt: w_reg_mux = r_rd_cnt;
            w_sel_scr:  w_reg_mux = r_scratch;
            w_sel_last: w_reg_mux = r_last_addr;
            default:    w_reg_mux = 8'h00;
        endcase
    end

    // Capture read data at request, present it one edge later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cap               <= 8'h00;
            o_reg_rd_data_valid <= 1'b0;
            o_reg_rd_data       <= 8'h00;
        end else begin
            if (w_reg_cap) begin
                r_cap <= w_reg_mux;
            end
            o_reg_rd_data_valid <= w_reg_resp;
            if (w_reg_resp) begin
                o_reg_rd_data <= r_cap;
            end
        end
    end

    // Control, status, scratch and address tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en        <= 1'b1;
            r_coll      <= 1'b0;
            r_ovr       <= 1'b0;
            r_scratch   <= 8'h00;
            r_last_addr <= 8'h00;
        end else begin
            if (w_reg_wr && w_sel_ctrl) begin
                r_en <= i_reg_wr_data[0];
            end
            if (w_reg_wr && w_sel_scr) begin
                r_scratch <= i_reg_wr_data;
            end
            if (w_mem_wr) begin
                r_last_addr <= 8'(i_address);
            end
            r_coll <= w_coll_set | (r_coll & ~w_clr_coll);
            r_ovr  <= w_ovr_set | (r_ovr & ~w_clr_ovr);
        end
    end

    // Saturating access counters; a register write clears them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt <= 8'h00;
            r_rd_cnt <= 8'h00;
        end else begin
            if (w_reg_wr && w_sel_wcnt) begin
                r_wr_cnt <= 8'h00;
            end else if (w_mem_wr && r_wr_cnt != 8'hFF) begin
                r_wr_cnt <= r_wr_cnt + 8'd1;
            end
            if (w_reg_wr && w_sel_rcnt) begin
                r_rd_cnt <= 8'h00;
            end else if (w_mem_rd && r_rd_cnt != 8'hFF) begin
                r_rd_cnt <= r_rd_cnt + 8'd1;
            end
        end
    end

    // Memory array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_wr) begin
            r_mem[i_address] <= i_wr_data;
        end
    end

    // Registered memory read port, holds when no read executes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if (w_mem_rd) begin
            o_rd_data <= r_mem[i_address];
        end
    end

endmodule

// File: tb/tb_spm_responder.sv
// tb_spm_responder: scoreboard bench for spm_responder.
// Expected values are hand-computed; honours SPM_WR_PROTECT_EN.
module tb_spm_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic [7:0] reg_addr = 8'h00;
    logic       reg_valid = 1'b0;
    logic       reg_wr_rd = 1'b0;
    logic [7:0] reg_wr_data = 8'h00;
    logic       reg_rd_valid;
    logic [7:0] reg_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q_d[$];
    int         q_due[$];
    string      q_nm[$];
    logic [7:0] m_d[$];
    string      m_nm[$];

    always #5 clk = ~clk;

    spm_responder #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_wr_en            (wr_en),
        .i_rd_en            (rd_en),
        .i_address          (address),
        .i_wr_data          (wr_data),
        .o_rd_data          (rd_data),
        .i_reg_addr         (reg_addr),
        .i_reg_access_valid (reg_valid),
        .i_reg_wr_rd        (reg_wr_rd),
        .i_reg_wr_data      (reg_wr_data),
        .o_reg_rd_data_valid(reg_rd_valid),
        .o_reg_rd_data      (reg_rd_data)
    );

    task automatic check8(input string nm, input logic [7:0] act,
                          input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents data.
    initial begin : monitor
        logic       rd_seen;
        logic [7:0] e;
        int         due;
        string      nm;
        forever begin
            @(posedge clk);
            cyc++;
            rd_seen = rd_en & ~rst;
            #1;
            if (rd_seen) begin
                if (m_d.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_rd: unexpected read data %02h, expected none",
                             rd_data);
                end else begin
                    e  = m_d.pop_front();
                    nm = m_nm.pop_front();
                    check8(nm, rd_data, e);
                end
            end
            if (reg_rd_valid === 1'b1) begin
                n_checks++;
                if (q_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL reg_strobe: unexpected strobe cycle %0d data %02h, expected none",
                             cyc, reg_rd_data);
                end else begin
                    e   = q_d.pop_front();
                    due = q_due.pop_front();
                    nm  = q_nm.pop_front();
                    if (reg_rd_data !== e || cyc != due) begin
                        n_fail++;
                        $display("FAIL %s: got %02h at cycle %0d, expected %02h at cycle %0d",
                                 nm, reg_rd_data, cyc, e, due);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    task automatic mem_wr(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        address = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic mem_rd(input logic [7:0] a, input logic [7:0] exp,
                          input string nm);
        m_d.push_back(exp);
        m_nm.push_back(nm);
        rd_en   = 1'b1;
        address = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic mem_coll(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] hold);
        m_d.push_back(hold);
        m_nm.push_back("coll_rd_hold");
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        address = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        reg_valid   = 1'b1;
        reg_wr_rd   = 1'b0;
        reg_addr    = a;
        reg_wr_data = d;
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic reg_req(input logic [7:0] a, input logic [7:0] exp,
                           input string nm);
        q_d.push_back(exp);
        q_due.push_back(cyc + 2);
        q_nm.push_back(nm);
        reg_valid = 1'b1;
        reg_wr_rd = 1'b1;
        reg_addr  = a;
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, input logic [7:0] exp,
                          input string nm);
        reg_req(a, exp, nm);
        @(negedge clk);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check8("rst_rd_data", rd_data, 8'h00);
        check8("rst_strobe", {7'b0, reg_rd_valid}, 8'h00);
        check8("rst_reg_data", reg_rd_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        reg_rd(8'h00, 8'h01, "rst_ctrl");
        reg_rd(8'h01, 8'h00, "rst_status");
        reg_rd(8'h02, 8'h00, "rst_wr_cnt");
        reg_rd(8'h03, 8'h00, "rst_rd_cnt");
        reg_rd(8'h04, 8'h00, "rst_scratch");
        reg_rd(8'h05, 8'h00, "rst_last_addr");

        for (int i = 0; i < 4; i++) begin
            mem_wr(8'h10 + 8'(i), 8'h11 + 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            mem_rd(8'h10 + 8'(i), 8'h11 + 8'(i), "mem_readback");
        end
        reg_rd(8'h02, 8'h04, "wr_cnt_4");
        reg_rd(8'h03, 8'h04, "rd_cnt_4");
        reg_rd(8'h05, 8'h13, "last_addr_13");

        reg_wr(8'h04, 8'hA5);
        reg_rd(8'h04, 8'hA5, "scratch_a5");
        reg_wr(8'h07, 8'hFF);
        reg_rd(8'h07, 8'h00, "unmapped_07");

        mem_coll(8'h20, 8'h5A, 8'h14);
        mem_rd(8'h20, 8'h5A, "coll_wr_done");
        reg_rd(8'h01, 8'h01, "status_coll");
        reg_rd(8'h02, 8'h05, "wr_cnt_coll");
        reg_rd(8'h03, 8'h05, "rd_cnt_coll");
        reg_wr(8'h01, 8'h01);
        reg_rd(8'h01, 8'h00, "status_w1c");

        reg_req(8'h04, 8'hA5, "ovr_first");
        reg_valid = 1'b1;
        reg_wr_rd = 1'b1;
        reg_addr  = 8'h00;
        @(negedge clk);
        reg_valid = 1'b0;
        @(negedge clk);
        reg_rd(8'h01, 8'h02, "status_ovr");
        reg_wr(8'h01, 8'h02);
        reg_rd(8'h01, 8'h00, "status_ovr_clr");

        for (int i = 0; i < 300; i++) begin
            mem_wr(8'(i), 8'(i) ^ 8'h3C);
        end
        reg_rd(8'h02, 8'hFF, "wr_cnt_sat");
        reg_rd(8'h05, 8'h2B, "last_addr_wrap");
        mem_rd(8'h10, 8'h2C, "mem_wrap_data");
        reg_wr(8'h02, 8'h5A);
        reg_rd(8'h02, 8'h00, "wr_cnt_clr");

        wr_en       = 1'b1;
        address     = 8'h40;
        wr_data     = 8'h77;
        reg_valid   = 1'b1;
        reg_wr_rd   = 1'b0;
        reg_addr    = 8'h02;
        reg_wr_data = 8'h00;
        @(negedge clk);
        wr_en     = 1'b0;
        reg_valid = 1'b0;
        reg_rd(8'h02, 8'h00, "clr_beats_inc");
        mem_rd(8'h40, 8'h77, "clr_edge_wr");
        reg_wr(8'h03, 8'h00);
        reg_rd(8'h03, 8'h00, "rd_cnt_clr");

        reg_wr(8'h00, 8'h00);
        reg_rd(8'h00, 8'h00, "ctrl_dis");
        mem_wr(8'h10, 8'hEE);
        mem_rd(8'h10, 8'h77, "rd_dis_hold");
        reg_wr(8'h00, 8'h01);
        mem_rd(8'h10, 8'h2C, "wr_dis_ignored");
        reg_rd(8'h02, 8'h00, "wr_cnt_dis");
        reg_rd(8'h03, 8'h01, "rd_cnt_dis");

        reg_wr(8'h00, 8'h03);
        mem_wr(8'h30, 8'h99);
`ifdef SPM_WR_PROTECT_EN
        reg_rd(8'h00, 8'h03, "ctrl_wp");
        mem_rd(8'h30, 8'h0C, "wp_mem_kept");
        reg_rd(8'h01, 8'h04, "status_wpv");
        reg_rd(8'h02, 8'h00, "wp_wr_cnt");
        reg_wr(8'h01, 8'h04);
        reg_rd(8'h01, 8'h00, "status_wpv_clr");
`else
        reg_rd(8'h00, 8'h01, "ctrl_no_wp");
        mem_rd(8'h30, 8'h99, "no_wp_mem");
        reg_rd(8'h01, 8'h00, "status_no_wpv");
        reg_rd(8'h02, 8'h01, "no_wp_wr_cnt");
`endif
        reg_wr(8'h00, 8'h01);

        reg_rd(8'h04, 8'hA5, "scratch_pre_rst");
        rst = 1'b1;
        #1;
        check8("rst_async_strobe", {7'b0, reg_rd_valid}, 8'h00);
        check8("rst_async_data", reg_rd_data, 8'h00);
        check8("rst_async_rd", rd_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        reg_rd(8'h00, 8'h01, "ctrl_after_rst");
        reg_rd(8'h04, 8'h00, "scratch_after_rst");
        mem_rd(8'h11, 8'h2D, "mem_not_reset");

        repeat (4) @(negedge clk);
        n_checks++;
        if (q_d.size() != 0 || m_d.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d reg and %0d mem responses missing, expected 0",
                     q_d.size(), m_d.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
